// File: rtl/uart_cfg_top.sv
// uart_cfg_top -- configurable UART transceiver (5..8 data bits, optional
// even/odd parity, 1 or 2 stop bits) with internal loopback.
//
// Ports
//   clk      in   system clock, all logic on its rising edge
//   rst      in   synchronous active-high reset
//   rx       in   serial input (asynchronous, idles high)
//   loop     in   1: receiver listens to the internal tx line instead of rx
//   newd     in   transmit request, sampled only while busytx = 0
//   dintx    in   transmit data, bits [DATA_BITS-1:0] used
//   tx       out  serial output (idles high)
//   busytx   out  high while a frame is on the line
//   donetx   out  one-cycle pulse when a frame completes
//   doutrx   out  last received data, zero-extended above DATA_BITS
//   donerx   out  one-cycle pulse, doutrx/perr/ferr valid in that cycle
//   perr     out  parity mismatch on the last frame
//   ferr     out  a stop bit was sampled low on the last frame
module uart_cfg_top #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       loop,
    input  logic       newd,
    input  logic [7:0] dintx,
    output logic       tx,
    output logic       busytx,
    output logic       donetx,
    output logic [7:0] doutrx,
    output logic       donerx,
    output logic       perr,
    output logic       ferr
);

    localparam int CPB   = clk_freq / baud_rate;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != 0);
    localparam logic       ODD_PAR   = (PARITY == 2);
    localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    // Parity bit that goes on the line for a (masked) data word.
    function automatic logic parity_of(input logic [7:0] d);
        return (^d) ^ ODD_PAR;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
    } rx_state_e;

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_data_q;
    logic             tx_par_q;
    logic             tx_q;
    logic             busy_q;
    logic             donetx_q;

    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_data_q;
    logic             rx_par_q;
    logic             stop_err_q;
    logic             sync1_q;
    logic             sync2_q;
    logic [7:0]       doutrx_q;
    logic             donerx_q;
    logic             perr_q;
    logic             ferr_q;

    logic rx_in_s;

    // Loopback feeds the registered tx line straight into the synchroniser.
    assign rx_in_s = loop ? tx_q : rx;

    // Transmit FSM; tx_data_q shifts right so the next bit is always at [1].
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            donetx_q   <= 1'b0;
        end else begin
            donetx_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (newd) begin
                        tx_data_q  <= dintx & DATA_MASK;
                        tx_par_q   <= parity_of(dintx & DATA_MASK);
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= 3'd0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == CPB_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_q       <= tx_data_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == CPB_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == DATA_LAST) begin
                            tx_bit_q <= 3'd0;
                            if (HAS_PAR) begin
                                tx_q       <= tx_par_q;
                                tx_state_q <= TX_PAR;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_bit_q  <= tx_bit_q + 3'd1;
                            tx_q      <= tx_data_q[1];
                            tx_data_q <= {1'b0, tx_data_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TX_PAR: begin
                    if (tx_cnt_q == CPB_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == CPB_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == STOP_LAST) begin
                            // busytx drops in the donetx cycle so a newd there is taken.
                            tx_bit_q   <= 3'd0;
                            busy_q     <= 1'b0;
                            donetx_q   <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser, preset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in_s;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM: half-bit wait to mid start bit, then one sample per bit time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_par_q   <= 1'b0;
            stop_err_q <= 1'b0;
            doutrx_q   <= 8'h00;
            donerx_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            donerx_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= 3'd0;
                        rx_data_q  <= 8'h00;
                        stop_err_q <= 1'b0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        // High again at mid start bit: it was a glitch.
                        rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CPB_LAST) begin
                        rx_cnt_q            <= '0;
                        rx_data_q[rx_bit_q] <= sync2_q;
                        if (rx_bit_q == DATA_LAST) begin
                            rx_bit_q   <= 3'd0;
                            rx_state_q <= HAS_PAR ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt_q == CPB_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_par_q   <= sync2_q;
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CPB_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == STOP_LAST) begin
                            rx_bit_q   <= 3'd0;
                            doutrx_q   <= rx_data_q;
                            perr_q     <= HAS_PAR & (rx_par_q ^ parity_of(rx_data_q));
                            ferr_q     <= stop_err_q | ~sync2_q;
                            donerx_q   <= 1'b1;
                            // A low last stop bit means the line is held low (break).
                            rx_state_q <= sync2_q ? RX_IDLE : RX_BREAK;
                        end else begin
                            stop_err_q <= stop_err_q | ~sync2_q;
                            rx_bit_q   <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                RX_BREAK: begin
                    if (sync2_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign busytx = busy_q;
    assign donetx = donetx_q;
    assign doutrx = doutrx_q;
    assign donerx = donerx_q;
    assign perr   = perr_q;
    assign ferr   = ferr_q;

endmodule

// File: tb/tb_uart_cfg_top.sv
// Scoreboard bench for uart_cfg_top: one 8N1 instance (loopback, framing,
// glitch, back-to-back, reset) and one 7E2 instance (parity, double stop).
module tb_uart_cfg_top;

    localparam int CPB = 104;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } rx_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    rx_exp_t rxq_a[$];
    rx_exp_t rxq_b[$];
    int      txq_a[$];

    logic       rx_a, loop_a, newd_a, tx_a, busytx_a, donetx_a, donerx_a, perr_a, ferr_a;
    logic [7:0] dintx_a, doutrx_a;
    logic       rx_b, loop_b, newd_b, tx_b, busytx_b, donetx_b, donerx_b, perr_b, ferr_b;
    logic [7:0] dintx_b, doutrx_b;

    uart_cfg_top dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .loop(loop_a), .newd(newd_a), .dintx(dintx_a),
        .tx(tx_a), .busytx(busytx_a), .donetx(donetx_a), .doutrx(doutrx_a),
        .donerx(donerx_a), .perr(perr_a), .ferr(ferr_a)
    );

    uart_cfg_top #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .loop(loop_b), .newd(newd_b), .dintx(dintx_b),
        .tx(tx_b), .busytx(busytx_b), .donetx(donetx_b), .doutrx(doutrx_b),
        .donerx(donerx_b), .perr(perr_b), .ferr(ferr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops an expectation whenever a done strobe appears.
    always @(negedge clk) begin
        rx_exp_t e;
        int      t;
        if (donerx_a === 1'b1) begin
            if (rxq_a.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_donerx_a: got donerx=1 expected none (cycle %0d)", cyc);
            end else begin
                e = rxq_a.pop_front();
                check("rx_a_data", {24'd0, doutrx_a}, {24'd0, e.d});
                check("rx_a_perr", {31'd0, perr_a}, {31'd0, e.p});
                check("rx_a_ferr", {31'd0, ferr_a}, {31'd0, e.f});
            end
        end
        if (donerx_b === 1'b1) begin
            if (rxq_b.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_donerx_b: got donerx=1 expected none (cycle %0d)", cyc);
            end else begin
                e = rxq_b.pop_front();
                check("rx_b_data", {24'd0, doutrx_b}, {24'd0, e.d});
                check("rx_b_perr", {31'd0, perr_b}, {31'd0, e.p});
                check("rx_b_ferr", {31'd0, ferr_b}, {31'd0, e.f});
            end
        end
        if (donetx_a === 1'b1) begin
            if (txq_a.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_donetx_a: got donetx=1 expected none (cycle %0d)", cyc);
            end else begin
                t = txq_a.pop_front();
                check("donetx_a_cycle", cyc, t);
                check("busytx_a_in_done", {31'd0, busytx_a}, 32'd0);
            end
        end
        if (donetx_b === 1'b1) begin
            n_checks++;
            $display("FAIL unexpected_donetx_b: got donetx=1 expected none (cycle %0d)", cyc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_a(input logic v, input int n);
        rx_a = v;
        wait_cyc(n);
    endtask

    task automatic line_b(input logic v, input int n);
        rx_b = v;
        wait_cyc(n);
    endtask

    // 8-bit frame on rx_a with a chosen stop level (no trailing idle).
    task automatic send_rx_a(input logic [7:0] d, input logic stop_v);
        line_a(1'b0, CPB);
        for (int i = 0; i < 8; i++) line_a(d[i], CPB);
        line_a(stop_v, CPB);
    endtask

    // 7E2 frame on rx_b; flip inverts the parity bit, s1 is the first stop bit.
    task automatic send_rx_b(input logic [6:0] d, input logic flip, input logic s1);
        line_b(1'b0, CPB);
        for (int i = 0; i < 7; i++) line_b(d[i], CPB);
        line_b((^d) ^ flip, CPB);
        line_b(s1, CPB);
        line_b(1'b1, CPB);
        line_b(1'b1, CPB);
    endtask

    // Issue a one-cycle newd on dut_a; donetx expected 1+1040 edges later.
    task automatic start_tx_a(input logic [7:0] d);
        newd_a  = 1'b1;
        dintx_a = d;
        txq_a.push_back(cyc + 1 + 10 * CPB);
        wait_cyc(1);
        newd_a = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rxq_a.size() == 0 && rxq_b.size() == 0 && txq_a.size() == 0) break;
            wait_cyc(1);
        end
        check(name, rxq_a.size() + rxq_b.size() + txq_a.size(), 32'd0);
    endtask

    task automatic wait_donetx_a(input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            wait_cyc(1);
            if (donetx_a === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("donetx_a_seen", seen, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        rx_a = 1'b1; loop_a = 1'b0; newd_a = 1'b0; dintx_a = 8'h00;
        rx_b = 1'b1; loop_b = 1'b0; newd_b = 1'b0; dintx_b = 8'h00;
        wait_cyc(3);

        // Reset state
        check("rst_tx",     {31'd0, tx_a},     32'd1);
        check("rst_busytx", {31'd0, busytx_a}, 32'd0);
        check("rst_donetx", {31'd0, donetx_a}, 32'd0);
        check("rst_doutrx", {24'd0, doutrx_a}, 32'd0);
        check("rst_donerx", {31'd0, donerx_a}, 32'd0);
        check("rst_perr",   {31'd0, perr_a},   32'd0);
        check("rst_ferr",   {31'd0, ferr_a},   32'd0);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 loopback of 0xA5
        loop_a = 1'b1;
        wait_cyc(2);
        rxq_a.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
        start_tx_a(8'hA5);
        check("busytx_after_newd", {31'd0, busytx_a}, 32'd1);
        check("tx_start_bit",      {31'd0, tx_a},     32'd0);
        drain("drain_loopback", 1500);
        wait_cyc(20);
        loop_a = 1'b0;
        wait_cyc(5);

        // Framing error: stop bit low, then line held low
        rxq_a.push_back('{d: 8'h3C, p: 1'b0, f: 1'b1});
        send_rx_a(8'h3C, 1'b0);
        line_a(1'b0, 3000);
        check("break_ferr_held", {31'd0, ferr_a}, 32'd1);
        check("break_one_donerx", rxq_a.size(), 32'd0);
        line_a(1'b1, 200);

        // Recovery after break
        rxq_a.push_back('{d: 8'h81, p: 1'b0, f: 1'b0});
        send_rx_a(8'h81, 1'b1);
        line_a(1'b1, CPB);
        drain("drain_recover", 500);

        // Glitch reject
        line_a(1'b0, 20);
        line_a(1'b1, 300);
        check("glitch_doutrx", {24'd0, doutrx_a}, 32'h81);

        // 7E2: good parity, flipped parity, odd-weight data, low first stop
        rxq_b.push_back('{d: 8'h55, p: 1'b0, f: 1'b0});
        send_rx_b(7'h55, 1'b0, 1'b1);
        rxq_b.push_back('{d: 8'h55, p: 1'b1, f: 1'b0});
        send_rx_b(7'h55, 1'b1, 1'b1);
        rxq_b.push_back('{d: 8'h07, p: 1'b0, f: 1'b0});
        send_rx_b(7'h07, 1'b0, 1'b1);
        rxq_b.push_back('{d: 8'h2A, p: 1'b0, f: 1'b1});
        send_rx_b(7'h2A, 1'b0, 1'b0);
        drain("drain_7e2", 500);

        // Back-to-back TX in loopback, with a mid-frame newd that must be ignored
        loop_a = 1'b1;
        wait_cyc(2);
        rxq_a.push_back('{d: 8'h00, p: 1'b0, f: 1'b0});
        rxq_a.push_back('{d: 8'hFF, p: 1'b0, f: 1'b0});
        start_tx_a(8'h00);
        wait_cyc(300);
        newd_a  = 1'b1;
        dintx_a = 8'h12;
        wait_cyc(1);
        newd_a  = 1'b0;
        check("busy_mid_frame", {31'd0, busytx_a}, 32'd1);
        wait_donetx_a(1200);
        start_tx_a(8'hFF);
        check("b2b_start_bit", {31'd0, tx_a}, 32'd0);
        drain("drain_b2b", 1500);
        wait_cyc(20);

        // Reset 500 cycles into a looped-back frame
        newd_a  = 1'b1;
        dintx_a = 8'h5A;
        wait_cyc(1);
        newd_a = 1'b0;
        wait_cyc(499);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_mid_tx",   {31'd0, tx_a},     32'd1);
        check("rst_mid_busy", {31'd0, busytx_a}, 32'd0);
        rst = 1'b0;
        wait_cyc(1200);
        rxq_a.push_back('{d: 8'hC3, p: 1'b0, f: 1'b0});
        start_tx_a(8'hC3);
        drain("drain_after_rst", 1500);
        loop_a = 1'b0;
        wait_cyc(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
